// File: rtl/serial_wb_pkg.sv
// Shared constants, register map and state encodings for the serial Wishbone-style bridge.
// Imported by the bridge top and the WS2812 transmitter.
package serial_wb_pkg;

  localparam logic [7:0] CMD_WR = 8'hA1;
  localparam logic [7:0] CMD_RD = 8'hA2;

  localparam logic [31:0] ADDR_LED    = 32'h0000_0000;
  localparam logic [31:0] ADDR_SPI    = 32'h0000_0004;
  localparam logic [31:0] ADDR_NEO    = 32'h0000_0008;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_000C;
  localparam logic [31:0] ADDR_ID     = 32'h0000_0010;

  localparam logic [31:0] ID_VALUE = 32'h5742_0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_EXEC,
    ST_RESP
  } parse_state_e;

  typedef enum logic [1:0] {
    NEO_IDLE,
    NEO_BIT,
    NEO_LATCH
  } neo_state_e;

  // Word match: the two low address bits select nothing.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] reg_addr);
    return (addr & ~32'h3) == reg_addr;
  endfunction

endpackage

// File: rtl/serial_wb_middle_if.sv
// Byte-stream pair between the UART and the bridge: s_axis carries received bytes in,
// m_axis carries response bytes out.
interface serial_wb_middle_if;

  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready
  );

endinterface

// File: rtl/serial_wb_middle_ws2812_tx.sv
// Single-pixel WS2812 transmitter: 24 GRB bits MSB first, then a low latch period.
// busy covers the whole frame including the latch time.
module ws2812_tx
  import serial_wb_pkg::*;
#(
  parameter int NEO_T0H  = 48,
  parameter int NEO_T1H  = 96,
  parameter int NEO_TBIT = 150,
  parameter int NEO_TRST = 6000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [23:0] data,
  input  logic        start,
  output logic        busy,
  output logic        o_neoPx
);

  localparam int CNT_MAX = (NEO_TRST > NEO_TBIT) ? NEO_TRST : NEO_TBIT;
  localparam int CNT_W   = $clog2(CNT_MAX);

  neo_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0]        bit_q;
  logic [23:0]       sh_q;
  logic              bit_end;
  logic              latch_end;

  assign bit_end   = (cnt_q == CNT_W'(NEO_TBIT - 1));
  assign latch_end = (cnt_q == CNT_W'(NEO_TRST - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= NEO_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NEO_IDLE:  if (start) state_d = NEO_BIT;
      NEO_BIT:   if (bit_end && bit_q == 5'd23) state_d = NEO_LATCH;
      NEO_LATCH: if (latch_end) state_d = NEO_IDLE;
      default:   state_d = NEO_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
    end else begin
      unique case (state_q)
        NEO_IDLE: begin
          if (start) begin
            sh_q  <= data;
            cnt_q <= '0;
            bit_q <= '0;
          end
        end
        NEO_BIT: begin
          if (bit_end) begin
            cnt_q <= '0;
            sh_q  <= {sh_q[22:0], 1'b0};
            bit_q <= bit_q + 5'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        NEO_LATCH: cnt_q <= latch_end ? '0 : cnt_q + 1'b1;
        default:   cnt_q <= '0;
      endcase
    end
  end

  // High time depends on the bit currently at the head of the shifter.
  assign o_neoPx = (state_q == NEO_BIT) &&
                   (cnt_q < (sh_q[23] ? CNT_W'(NEO_T1H) : CNT_W'(NEO_T0H)));
  assign busy    = (state_q != NEO_IDLE);

endmodule

// File: rtl/serial_wb_middle.sv
// Frame parser between the UART byte streams and the board peripherals: LED bank,
// serial LED shifter and one WS2812 pixel, with ack/read-data responses on m_axis.
module serial_wb_middle
  import serial_wb_pkg::*;
#(
  parameter int SPI_DIV    = 60,
  parameter int NEO_T0H    = 48,
  parameter int NEO_T1H    = 96,
  parameter int NEO_TBIT   = 150,
  parameter int NEO_TRST   = 6000,
  parameter int RX_TIMEOUT = 1_200_000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  serial_wb_middle_if.slave   axis,
  output logic [5:0]          o_led,
  output logic                o_led_clk,
  output logic                o_led_data,
  output logic                o_neoPx
);

  localparam int TO_W  = $clog2(RX_TIMEOUT + 1);
  localparam int DIV_W = $clog2(SPI_DIV);

  parse_state_e     state_q, state_d;
  logic [1:0]       byte_cnt_q;
  logic             is_write_q;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic [39:0]      resp_q;
  logic [2:0]       resp_left_q;
  logic [TO_W-1:0]  timer_q;

  logic             byte_take;
  logic             byte_out;
  logic             timeout_hit;
  logic             in_frame;
  logic [31:0]      rd_data;

  logic [5:0]       led_q;
  logic [31:0]      spi_reg_q;
  logic [23:0]      neo_reg_q;

  logic             exec_wr;
  logic             spi_start;
  logic             neo_start;
  logic             neo_busy;

  logic             spi_busy_q;
  logic [31:0]      spi_sh_q;
  logic [DIV_W-1:0] spi_div_q;
  logic [4:0]       spi_bit_q;

  assign axis.s_axis_tready = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign axis.m_axis_tvalid = (state_q == ST_RESP);
  assign axis.m_axis_tdata  = resp_q[39:32];

  assign byte_take   = axis.s_axis_tvalid && axis.s_axis_tready;
  assign byte_out    = axis.m_axis_tvalid && axis.m_axis_tready;
  assign in_frame    = (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign timeout_hit = in_frame && !byte_take && (timer_q == TO_W'(RX_TIMEOUT - 1));

  // NOTE: all sequential state uses <= so every flop samples the pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets its default first so no branch leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (byte_take && (axis.s_axis_tdata == CMD_WR || axis.s_axis_tdata == CMD_RD))
          state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (byte_take && byte_cnt_q == 2'd3) state_d = is_write_q ? ST_DATA : ST_EXEC;
        else if (timeout_hit)                state_d = ST_IDLE;
      end
      ST_DATA: begin
        if (byte_take && byte_cnt_q == 2'd3) state_d = ST_EXEC;
        else if (timeout_hit)                state_d = ST_IDLE;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (byte_out && resp_left_q == 3'd1) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      byte_cnt_q  <= '0;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_q      <= '0;
      resp_left_q <= '0;
      timer_q     <= '0;
    end else begin
      timer_q <= (in_frame && !byte_take) ? timer_q + 1'b1 : '0;
      if (byte_take) begin
        unique case (state_q)
          ST_IDLE: begin
            is_write_q <= (axis.s_axis_tdata == CMD_WR);
            byte_cnt_q <= '0;
          end
          ST_ADDR: begin
            addr_q     <= {addr_q[23:0], axis.s_axis_tdata};
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
          ST_DATA: begin
            data_q     <= {data_q[23:0], axis.s_axis_tdata};
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
          default: ;
        endcase
      end
      if (state_q == ST_EXEC) begin
        resp_q      <= is_write_q ? {CMD_WR, 32'd0} : {CMD_RD, rd_data};
        resp_left_q <= is_write_q ? 3'd1 : 3'd5;
      end else if (byte_out) begin
        resp_q      <= {resp_q[31:0], 8'h00};
        resp_left_q <= resp_left_q - 3'd1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if      (addr_hit(addr_q, ADDR_LED))    rd_data = {26'd0, led_q};
    else if (addr_hit(addr_q, ADDR_SPI))    rd_data = spi_reg_q;
    else if (addr_hit(addr_q, ADDR_NEO))    rd_data = {8'd0, neo_reg_q};
    else if (addr_hit(addr_q, ADDR_STATUS)) rd_data = {30'd0, neo_busy, spi_busy_q};
    else if (addr_hit(addr_q, ADDR_ID))     rd_data = ID_VALUE;
  end

  // Engine writes landing while busy are dropped; the ack still goes out.
  assign exec_wr   = (state_q == ST_EXEC) && is_write_q;
  assign spi_start = exec_wr && addr_hit(addr_q, ADDR_SPI) && !spi_busy_q;
  assign neo_start = exec_wr && addr_hit(addr_q, ADDR_NEO) && !neo_busy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      led_q     <= '0;
      spi_reg_q <= '0;
      neo_reg_q <= '0;
    end else begin
      if (exec_wr && addr_hit(addr_q, ADDR_LED)) led_q <= data_q[5:0];
      if (spi_start) spi_reg_q <= data_q;
      if (neo_start) neo_reg_q <= data_q[23:0];
    end
  end

  assign o_led = ~led_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      spi_busy_q <= 1'b0;
      spi_sh_q   <= '0;
      spi_div_q  <= '0;
      spi_bit_q  <= '0;
    end else if (spi_start) begin
      spi_busy_q <= 1'b1;
      spi_sh_q   <= data_q;
      spi_div_q  <= '0;
      spi_bit_q  <= '0;
    end else if (spi_busy_q) begin
      if (spi_div_q == DIV_W'(SPI_DIV - 1)) begin
        spi_div_q <= '0;
        spi_sh_q  <= {spi_sh_q[30:0], 1'b0};
        spi_bit_q <= spi_bit_q + 5'd1;
        if (spi_bit_q == 5'd31) spi_busy_q <= 1'b0;
      end else begin
        spi_div_q <= spi_div_q + 1'b1;
      end
    end
  end

  // Data leads each bit; the clock rises at mid-bit so the receiver samples stable data.
  assign o_led_data = spi_busy_q && spi_sh_q[31];
  assign o_led_clk  = spi_busy_q && (spi_div_q >= DIV_W'(SPI_DIV / 2));

  ws2812_tx #(
    .NEO_T0H  (NEO_T0H),
    .NEO_T1H  (NEO_T1H),
    .NEO_TBIT (NEO_TBIT),
    .NEO_TRST (NEO_TRST)
  ) u_ws2812_tx (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .data    (data_q[23:0]),
    .start   (neo_start),
    .busy    (neo_busy),
    .o_neoPx (o_neoPx)
  );

endmodule

// File: tb/tb_serial_wb_middle.sv
// Directed plus randomized frames against a register-level model of the bridge,
// with cycle monitors on the serial LED and WS2812 lines.
module tb_serial_wb_middle;

  localparam int SPI_DIV    = 8;
  localparam int NEO_T0H    = 4;
  localparam int NEO_T1H    = 8;
  localparam int NEO_TBIT   = 12;
  localparam int NEO_TRST   = 50;
  localparam int RX_TIMEOUT = 200;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [5:0] o_led;
  logic       o_led_clk;
  logic       o_led_data;
  logic       o_neoPx;

  serial_wb_middle_if axis ();

  always #5 i_clk = ~i_clk;

  serial_wb_middle #(
    .SPI_DIV    (SPI_DIV),
    .NEO_T0H    (NEO_T0H),
    .NEO_T1H    (NEO_T1H),
    .NEO_TBIT   (NEO_TBIT),
    .NEO_TRST   (NEO_TRST),
    .RX_TIMEOUT (RX_TIMEOUT)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .axis       (axis),
    .o_led      (o_led),
    .o_led_clk  (o_led_clk),
    .o_led_data (o_led_data),
    .o_neoPx    (o_neoPx)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Register-level model of the bridge.
  logic [5:0]  m_led;
  logic [31:0] m_spi;
  logic [23:0] m_neo;
  logic        m_spi_busy;
  logic        m_neo_busy;

  // Monitor state.
  int          spi_rises, spi_bad_period, spi_high, spi_last;
  logic [31:0] spi_word;
  logic        spi_prev;
  int          neo_widths[$];
  int          neo_run;

  logic [31:0] addr_pool [10] = '{32'h0, 32'h1, 32'h3, 32'h10, 32'h13, 32'h14,
                                  32'h40, 32'h8000_0000, 32'h0F, 32'h4};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case ({a[31:2], 2'b00})
      32'h00:  return {26'd0, m_led};
      32'h04:  return m_spi;
      32'h08:  return {8'd0, m_neo};
      32'h0C:  return {30'd0, m_neo_busy, m_spi_busy};
      32'h10:  return 32'h5742_0001;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    case ({a[31:2], 2'b00})
      32'h00: m_led = d[5:0];
      32'h04: if (!m_spi_busy) begin m_spi = d; m_spi_busy = 1'b1; end
      32'h08: if (!m_neo_busy) begin m_neo = d[23:0]; m_neo_busy = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_led = '0; m_spi = '0; m_neo = '0; m_spi_busy = 1'b0; m_neo_busy = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge i_clk);
    axis.s_axis_tdata  = b;
    axis.s_axis_tvalid = 1'b1;
    while (!axis.s_axis_tready && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    check("tready_wait_expired", 32'(n >= 1000), 32'd0);
    @(posedge i_clk);
    #1 axis.s_axis_tvalid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n = 0;
    @(negedge i_clk);
    axis.m_axis_tready = 1'b1;
    while (!axis.m_axis_tvalid && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("tvalid_wait_expired", 32'(n >= 200), 32'd0);
    b = axis.m_axis_tdata;
    @(posedge i_clk);
    #1 axis.m_axis_tready = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    logic [7:0] b;
    send_byte(8'hA1);
    send_word(a);
    send_word(d);
    recv_byte(b);
    check("write_ack", {24'd0, b}, 32'h0000_00A1);
    model_write(a, d);
  endtask

  task automatic read_resp(input logic [31:0] a, input string tag);
    logic [39:0] exp;
    logic [7:0]  b;
    exp = {8'hA2, model_read(a)};
    for (int i = 4; i >= 0; i--) begin
      recv_byte(b);
      check(tag, {24'd0, b}, {24'd0, exp[8*i +: 8]});
    end
  endtask

  task automatic do_read(input logic [31:0] a, input string tag);
    send_byte(8'hA2);
    send_word(a);
    read_resp(a, tag);
  endtask

  task automatic watch_quiet(input int cycles, input string tag);
    int seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge i_clk);
      if (axis.m_axis_tvalid) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [7:0]  first;
    int          viol, n;

    model_reset();
    i_rst              = 1'b1;
    axis.s_axis_tdata  = '0;
    axis.s_axis_tvalid = 1'b0;
    axis.m_axis_tready = 1'b0;
    #12;
    check("rst_o_led",      {26'd0, o_led}, 32'h3F);
    check("rst_s_tready",   {31'd0, axis.s_axis_tready}, 32'd1);
    check("rst_m_tvalid",   {31'd0, axis.m_axis_tvalid}, 32'd0);
    check("rst_m_tdata",    {24'd0, axis.m_axis_tdata}, 32'd0);
    check("rst_led_clk",    {31'd0, o_led_clk}, 32'd0);
    check("rst_led_data",   {31'd0, o_led_data}, 32'd0);
    check("rst_neopx",      {31'd0, o_neoPx}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // LED write and ID read.
    do_write(32'h0, 32'h0000_002A);
    check("led_pins_2a", {26'd0, o_led}, 32'h15);
    do_read(32'h10, "read_id");

    // Randomized accesses to LED, read-only and unmapped addresses.
    for (int k = 0; k < 14; k++) begin
      a = addr_pool[$urandom_range(0, 9)];
      d = $urandom;
      if ($urandom_range(0, 1) == 1 && a != 32'h4) do_write(a, d);
      else                                        do_read(a, "rand_read");
      check("rand_led_pins", {26'd0, o_led}, {26'd0, ~m_led});
    end

    // Unknown command byte is dropped silently.
    send_byte(8'h55);
    watch_quiet(40, "unknown_cmd_quiet");
    do_read(32'h0, "read_after_unknown");

    // Serial LED shift of 0x80000001 with concurrent status read.
    spi_rises = 0; spi_bad_period = 0; spi_high = 0; spi_last = -1;
    spi_word = '0; spi_prev = 1'b0;
    fork
      begin
        for (int c = 0; c < 32 * SPI_DIV + 120; c++) begin
          @(negedge i_clk);
          if (o_led_clk) spi_high++;
          if (o_led_clk && !spi_prev) begin
            if (spi_last >= 0 && (c - spi_last) != SPI_DIV) spi_bad_period++;
            spi_last = c;
            spi_word = {spi_word[30:0], o_led_data};
            spi_rises++;
          end
          spi_prev = o_led_clk;
        end
      end
      begin
        do_write(32'h4, 32'h8000_0001);
        do_read(32'hC, "status_spi_busy");
      end
    join
    check("spi_pulse_count", spi_rises, 32);
    check("spi_bad_periods", spi_bad_period, 0);
    check("spi_clk_high_cycles", spi_high, 32 * (SPI_DIV / 2));
    check("spi_shifted_word", spi_word, 32'h8000_0001);
    check("spi_idle_clk", {31'd0, o_led_clk}, 32'd0);
    check("spi_idle_data", {31'd0, o_led_data}, 32'd0);
    m_spi_busy = 1'b0;
    do_read(32'hC, "status_spi_done");
    do_read(32'h4, "spi_reg_readback");

    // WS2812 frame 0xFF0000 plus a dropped write while busy.
    neo_widths.delete();
    neo_run = 0;
    fork
      begin
        for (int c = 0; c < 24 * NEO_TBIT + NEO_TRST + 200; c++) begin
          @(negedge i_clk);
          if (o_neoPx) neo_run++;
          else if (neo_run > 0) begin
            neo_widths.push_back(neo_run);
            neo_run = 0;
          end
        end
      end
      begin
        do_write(32'h8, 32'h00FF_0000);
        do_write(32'h8, 32'h0000_FFFF);
        do_read(32'hC, "status_neo_busy");
        do_read(32'h8, "neo_reg_kept");
      end
    join
    check("neo_pulse_count", neo_widths.size(), 24);
    viol = 0;
    foreach (neo_widths[i]) if (neo_widths[i] != ((i < 8) ? NEO_T1H : NEO_T0H)) viol++;
    check("neo_pulse_widths", viol, 0);
    check("neo_line_idle", {31'd0, o_neoPx}, 32'd0);
    m_neo_busy = 1'b0;
    do_read(32'hC, "status_neo_done");

    // A stall shorter than the timeout keeps the frame alive.
    send_byte(8'hA1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    repeat (RX_TIMEOUT - 50) @(negedge i_clk);
    send_byte(8'h00);
    send_word(32'h0000_003C);
    recv_byte(first);
    check("short_stall_ack", {24'd0, first}, 32'h0000_00A1);
    model_write(32'h0, 32'h3C);
    check("short_stall_led", {26'd0, o_led}, {26'd0, ~m_led});

    // Stalled frame times out silently; next read answered normally.
    send_byte(8'hA1);
    send_byte(8'h00);
    send_byte(8'h00);
    watch_quiet(RX_TIMEOUT + 20, "timeout_quiet");
    do_read(32'h10, "read_after_timeout");

    // Backpressure on a read response.
    send_byte(8'hA2);
    send_word(32'h10);
    n = 0;
    while (!axis.m_axis_tvalid && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check("bp_tvalid_wait_expired", 32'(n >= 50), 32'd0);
    viol = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_clk);
      if (!axis.m_axis_tvalid || axis.m_axis_tdata != 8'hA2) viol++;
    end
    check("bp_hold_violations", viol, 0);
    read_resp(32'h10, "bp_read_id");

    // Asynchronous reset in the middle of a shift.
    do_write(32'h4, 32'hA5A5_A5A5);
    repeat (40) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("midrst_led_clk",  {31'd0, o_led_clk}, 32'd0);
    check("midrst_led_data", {31'd0, o_led_data}, 32'd0);
    check("midrst_o_led",    {26'd0, o_led}, 32'h3F);
    check("midrst_s_tready", {31'd0, axis.s_axis_tready}, 32'd1);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    do_read(32'hC, "status_after_rst");
    do_read(32'h4, "spi_reg_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
